// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_mul_pkg;

  // Controller states, fixed 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default operand width.
  localparam int DEF_WIDTH = 16;

  // Product width for a given operand width.
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/seq_mul_ctrl_if.sv
// Operand/product handshake bundle between producer, multiplier and consumer.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the product side.
interface seq_mul_ctrl_if #(
  parameter int WIDTH = seq_mul_pkg::DEF_WIDTH
) ();

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  // Producer/consumer side.
  modport master (
    output in_valid, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, product
  );

  // Multiplier controller side.
  modport slave (
    input  in_valid, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/seq_mul_ctrl_shift_add_step.sv
// One conditional add-and-shift step of an unsigned shift-add multiplier.
// Latency: combinational.
// Backpressure: none; the controller decides when the result is registered.
module shift_add_step
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [prod_w(WIDTH)-1:0] acc,
  input  logic [prod_w(WIDTH)-1:0] mcand,
  input  logic [WIDTH-1:0]         mplier,
  output logic [prod_w(WIDTH)-1:0] acc_nxt,
  output logic [prod_w(WIDTH)-1:0] mcand_nxt,
  output logic [WIDTH-1:0]         mplier_nxt
);

  localparam int PW = prod_w(WIDTH);

  // Full-width adder: the largest product (2^WIDTH-1)^2 always fits, so no carry-out.
  assign acc_nxt    = mplier[0] ? (acc + mcand) : acc;
  assign mcand_nxt  = {mcand[PW-2:0], 1'b0};
  assign mplier_nxt = {1'b0, mplier[WIDTH-1:1]};

endmodule

// File: rtl/seq_mul_ctrl.sv
// Sequencing controller for a shift-add unsigned multiplier (optional early exit: SEQ_MUL_EARLY_TERM_EN).
// Latency: out_valid rises WIDTH edges after accept (early exit: highest set multiplier bit index + 1).
// Backpressure: in_ready low outside IDLE or while flush; DONE holds product/out_valid until out_ready.
module seq_mul_ctrl
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  output logic         busy,
  seq_mul_ctrl_if.slave bus
);

  localparam int PW = prod_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    product_r;
  logic             out_valid_r;
  logic             busy_r;

  logic [PW-1:0]    acc_nxt;
  logic [PW-1:0]    mcand_nxt;
  logic [WIDTH-1:0] mplier_nxt;
  logic             last_step;

  shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .mcand      (mcand_r),
    .mplier     (mplier_r),
    .acc_nxt    (acc_nxt),
    .mcand_nxt  (mcand_nxt),
    .mplier_nxt (mplier_nxt)
  );

`ifdef SEQ_MUL_EARLY_TERM_EN
  // Stop as soon as no multiplier bits remain; the fixed count still bounds the run.
  assign last_step = (cnt == LAST_CNT) || (mplier_nxt == '0);
`else
  assign last_step = (cnt == LAST_CNT);
`endif

  // flush blocks an accept in the same cycle it is seen.
  assign bus.in_ready  = (state == IDLE) && !flush;
  assign bus.out_valid = out_valid_r;
  assign bus.product   = product_r;
  assign busy          = busy_r;

  // Controller FSM: owns operand, accumulator, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      mcand_r     <= '0;
      mplier_r    <= '0;
      cnt         <= '0;
      product_r   <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (flush) begin
      // Abort: drop the in-flight operation but keep the last delivered product.
      state       <= IDLE;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand_r  <= {{WIDTH{1'b0}}, bus.multiplicand};
            mplier_r <= bus.multiplier;
            acc      <= '0;
            cnt      <= '0;
            busy_r   <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc      <= acc_nxt;
          mcand_r  <= mcand_nxt;
          mplier_r <= mplier_nxt;
          cnt      <= cnt + CNT_W'(1);
          if (last_step) begin
            product_r   <= acc_nxt;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Self-checking bench for seq_mul_ctrl: directed vectors, scoreboard on the product handshake.
// Latency: n/a.
// Backpressure: exercises held out_ready, flush and mid-run reset.
module tb_seq_mul_ctrl;

  localparam int W = 16;

`ifdef SEQ_MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  // Hand-computed products.
  vec_t vecs [6] = '{
    '{16'h0003, 16'h0005, 32'h0000_000F},
    '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001},
    '{16'h8000, 16'h0002, 32'h0001_0000},
    '{16'h0007, 16'h0002, 32'h0000_000E},
    '{16'h0009, 16'h0000, 32'h0000_0000},
    '{16'h1234, 16'h0010, 32'h0001_2340}
  };

  logic clk = 1'b0;
  logic rst_n;
  logic flush = 1'b0;
  logic busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  seq_mul_ctrl_if #(.WIDTH(W)) bus ();

  seq_mul_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Expected cycles from accept to out_valid.
  function automatic int exp_lat(input logic [15:0] b);
    int l;
    l = W;
    if (EARLY) begin
      l = 1;
      for (int i = 0; i < W; i++) if (b[i]) l = i + 1;
    end
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
    bus.in_valid     = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int lat);
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    check(name, n, lat);
  endtask

  // Scoreboard monitor: compare whenever a product handshake will complete at the next edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_product: got=0x%0h expected=none", bus.product);
      end else begin
        check("product", bus.product, exp_q.pop_front());
      end
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    logic seen;
    bus.in_valid     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.out_ready    = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", bus.product, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Directed vectors.
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].p);
      start_op(vecs[i].a, vecs[i].b);
      check("run_in_ready", bus.in_ready, 0);
      check("run_busy", busy, 1);
      wait_valid("latency", exp_lat(vecs[i].b));
      tick();
      check("idle_busy", busy, 0);
    end

    // Operands changed during RUN are ignored.
    exp_q.push_back(32'h0000_000F);
    start_op(16'h0003, 16'h0005);
    bus.multiplicand = 16'hFFFF;
    bus.multiplier   = 16'hFFFF;
    wait_valid("latency_stable", exp_lat(16'h0005));
    tick();

    // Backpressure: hold out_ready low for 5 cycles.
    bus.out_ready = 1'b0;
    exp_q.push_back(32'h0001_0201);
    start_op(16'h0101, 16'h0101);
    wait_valid("latency_bp", exp_lat(16'h0101));
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_product", bus.product, 32'h0001_0201);
      check("bp_in_ready", bus.in_ready, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_idle_in_ready", bus.in_ready, 1);
    check("bp_idle_out_valid", bus.out_valid, 0);
    check("bp_idle_product", bus.product, 32'h0001_0201);

    // Flush at RUN cycle 7: no result, previous product retained.
    start_op(16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 6; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_product", bus.product, 32'h0001_0201);
    seen = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      seen = seen | bus.out_valid;
    end
    check("flush_no_valid", seen, 0);

    // Flush in IDLE blocks an accept.
    flush            = 1'b1;
    bus.in_valid     = 1'b1;
    bus.multiplicand = 16'h0002;
    bus.multiplier   = 16'h0002;
    #1;
    check("flush_idle_in_ready", bus.in_ready, 0);
    tick();
    check("flush_idle_busy", busy, 0);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("flush_idle_release", bus.in_ready, 1);

    // Asynchronous reset mid-RUN discards the operation.
    start_op(16'h1234, 16'h5678);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_product", bus.product, 0);
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Recovery after reset.
    exp_q.push_back(32'h0000_ABCD);
    start_op(16'hABCD, 16'h0001);
    wait_valid("latency_recover", exp_lat(16'h0001));
    tick();
    tick();

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
